spi_master_gen: RTL and testbench

- Parametrised SPI master and successor to the fixed fast/slow SPI engine.
- Programmable clock divider, all four CPOL/CPHA modes, 8/16/24/32-bit frames, selectable byte order, and NCS decoded active-low chip selects with lead/lag timing.
- Sits on the RISC5 I/O bus behind the SD-card and flash controllers; the CPU writes config and data and polls rdy.

---
 rtl/spi_master_gen_pkg.sv | 34 +++
 rtl/spi_master_gen_if.sv | 41 ++++
 rtl/spi_master_gen_clkgen.sv | 40 ++++
 rtl/spi_master_gen.sv | 163 ++++++++++++++++
 tb/tb_spi_master_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_gen_pkg.sv
// Shared types and helpers for the generic SPI master.
// State encoding, frame-length codes and serial bit ordering.
package spi_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    LAG,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2,
    LEN32 = 2'd3
  } len_t;

  localparam logic MOSI_IDLE = 1'b1;

  // Serial bit i -> word bit; nb is the byte count minus one.
  function automatic int bitpos(
    input int   i,
    input logic lsb,
    input int   nb
  );
    int k;
    k = i / 8;
    return lsb ? 8 * k + 7 - i % 8
               : 8 * (nb - k) + 7 - i % 8;
  endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// CPU-side config/data bus plus SPI pins for spi_master_gen.
// master = the SPI engine, slave = the bus owner driving it.
interface spi_master_gen_if #(
  parameter int MAXW = 32,
  parameter int NCS  = 4,
  parameter int DIVW = 8
);
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

  logic            start;
  logic [DIVW-1:0] div;
  logic            cpol;
  logic            cpha;
  logic [1:0]      nbytes;
  logic            lsbyte;
  logic [CSW-1:0]  cs_sel;
  logic [MAXW-1:0] dataTx;
  logic [MAXW-1:0] dataRx;
  logic            rdy;
  logic            MISO;
  logic            MOSI;
  logic            SCLK;
  logic [NCS-1:0]  SS_n;

  modport master (
    input  start, div, cpol, cpha,
    input  nbytes, lsbyte, cs_sel,
    input  dataTx, MISO,
    output dataRx, rdy, MOSI,
    output SCLK, SS_n
  );

  modport slave (
    output start, div, cpol, cpha,
    output nbytes, lsbyte, cs_sel,
    output dataTx, MISO,
    input  dataRx, rdy, MOSI,
    input  SCLK, SS_n
  );

endinterface

// File: rtl/spi_master_gen_clkgen.sv
// Half-period counter and SCLK edge generator.
// Counts 0..div while running; SCLK only toggles during XFER.
module spi_gen_clkgen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_run,
  input  logic            i_xfer,
  input  logic            i_cpol,
  output logic            o_tick,
  output logic            o_lead_edge,
  output logic            o_trail_edge,
  output logic            o_sclk
);

  logic [DIVW-1:0] r_cnt;
  logic            r_ph;

  assign o_tick = i_run && (r_cnt == i_div);
  assign o_lead_edge  = o_tick && i_xfer && !r_ph;
  assign o_trail_edge = o_tick && i_xfer && r_ph;
  assign o_sclk = i_cpol ^ r_ph;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_ph  <= 1'b0;
    end else begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      if (o_tick && i_xfer)
        r_ph <= ~r_ph;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: 4 modes, 8..MAXW bit frames, decoded selects.
// Config is latched at start; CPU polls rdy for completion.
module spi_master_gen
  import spi_gen_pkg::*;
#(
  parameter int MAXW = 32,
  parameter int NCS  = 4,
  parameter int DIVW = 8
) (
  input logic              clk,
  input logic              rst,
  spi_master_gen_if.master bus
);

  localparam int MAXB = MAXW / 8;
  localparam int IW   = $clog2(MAXW);
  localparam int HW   = $clog2(2 * MAXW);
  localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [DIVW-1:0] r_div;
  logic            r_cpol;
  logic            r_cpha;
  logic            r_lsb;
  logic [1:0]      r_nb;
  logic [CSW-1:0]  r_cs;
  logic [MAXW-1:0] r_tx;
  logic [MAXW-1:0] r_rx;
  logic [MAXW-1:0] r_datarx;
  logic [HW-1:0]   r_hp;
  logic [IW-1:0]   r_txi;
  logic [IW-1:0]   r_rxi;
  logic            r_txv;

  logic            w_tick;
  logic            w_lead;
  logic            w_trail;
  logic            w_sclk;
  logic            w_act;
  logic            w_xfer;
  logic            w_go;
  logic            w_sample;
  logic            w_txadv;
  logic            w_txlast;
  logic [HW-1:0]   w_hplast;
  logic [1:0]      w_nbc;
  logic [IW-1:0]   w_txpos;
  logic [IW-1:0]   w_rxpos;
  logic [NCS-1:0]  w_ss;

  assign w_act  = (r_state == LEAD) ||
                  (r_state == XFER) ||
                  (r_state == LAG);
  assign w_xfer = (r_state == XFER);
  assign w_go   = (r_state == IDLE) && bus.start;

  assign w_nbc = (int'(bus.nbytes) > MAXB - 1)
               ? 2'(MAXB - 1) : bus.nbytes;

  assign w_hplast = HW'(16 * (int'(r_nb) + 1) - 1);
  assign w_txlast = r_txi == IW'(8 * (int'(r_nb) + 1) - 1);

  assign w_txpos = IW'(bitpos(int'(r_txi), r_lsb, int'(r_nb)));
  assign w_rxpos = IW'(bitpos(int'(r_rxi), r_lsb, int'(r_nb)));

  assign w_sample = r_cpha ? w_trail : w_lead;
  // cpha=1 presents bit 0 on the first leading edge, not before it
  assign w_txadv  = r_cpha ? w_lead : (w_trail && !w_txlast);

  spi_gen_clkgen #(
    .DIVW(DIVW)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .i_div       (r_div),
    .i_run       (w_act),
    .i_xfer      (w_xfer),
    .i_cpol      (r_cpol),
    .o_tick      (w_tick),
    .o_lead_edge (w_lead),
    .o_trail_edge(w_trail),
    .o_sclk      (w_sclk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = LEAD;
      LEAD:    if (w_tick) w_next = XFER;
      XFER:    if (w_tick && r_hp == w_hplast)
                 w_next = LAG;
      LAG:     if (w_tick) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div    <= '0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_lsb    <= 1'b0;
      r_nb     <= '0;
      r_cs     <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_datarx <= '0;
      r_hp     <= '0;
      r_txi    <= '0;
      r_rxi    <= '0;
      r_txv    <= 1'b0;
    end else begin
      if (w_go) begin
        r_div  <= bus.div;
        r_cpol <= bus.cpol;
        r_cpha <= bus.cpha;
        r_lsb  <= bus.lsbyte;
        r_nb   <= w_nbc;
        r_cs   <= bus.cs_sel;
        r_tx   <= bus.dataTx;
        r_rx   <= '0;
        r_hp   <= '0;
        r_txi  <= '0;
        r_rxi  <= '0;
        r_txv  <= ~bus.cpha;
      end
      if (w_xfer && w_tick)
        r_hp <= r_hp + 1'b1;
      if (w_sample) begin
        r_rx[w_rxpos] <= bus.MISO;
        r_rxi         <= r_rxi + 1'b1;
      end
      if (w_txadv) begin
        if (r_txv) r_txi <= r_txi + 1'b1;
        r_txv <= 1'b1;
      end
      if (r_state == DONE)
        r_datarx <= r_rx;
    end
  end

  always_comb begin
    w_ss = '1;
    for (int i = 0; i < NCS; i++)
      if (w_act && r_cs == CSW'(i))
        w_ss[i] = 1'b0;
  end

  assign bus.MOSI   = (w_act && r_txv) ? r_tx[w_txpos]
                                       : MOSI_IDLE;
  assign bus.SCLK   = w_sclk;
  assign bus.SS_n   = w_ss;
  assign bus.rdy    = (r_state == IDLE);
  assign bus.dataRx = r_datarx;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen with a frame scoreboard.
// Two instances: NCS=4 (main) and NCS=3 (select range).
module tb_spi_master_gen;

  typedef struct {
    logic [31:0] rx;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic        loop = 1'b1;
  logic [31:0] sl_vec = '0;
  logic [4:0]  k = '0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  spi_master_gen_if #(.MAXW(32), .NCS(4), .DIVW(8)) ifa ();
  spi_master_gen_if #(.MAXW(32), .NCS(3), .DIVW(8)) ifb ();

  assign ifa.MISO = loop ? ifa.MOSI : sl_vec[k];
  assign ifb.MISO = ifb.MOSI;

  spi_master_gen #(.MAXW(32), .NCS(4), .DIVW(8)) dut_a (
    .clk(clk), .rst(rst_n), .bus(ifa.master)
  );

  spi_master_gen #(.MAXW(32), .NCS(3), .DIVW(8)) dut_b (
    .clk(clk), .rst(rst_n), .bus(ifb.master)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic c_cpol, c_cpha,
                         input logic [7:0] c_div,
                         input logic [1:0] c_nb,
                         input logic c_lsb,
                         input logic [1:0] c_cs,
                         input logic [31:0] c_tx);
    ifa.cpol = c_cpol; ifb.cpol = c_cpol;
    ifa.cpha = c_cpha; ifb.cpha = c_cpha;
    ifa.div = c_div; ifb.div = c_div;
    ifa.nbytes = c_nb; ifb.nbytes = c_nb;
    ifa.lsbyte = c_lsb; ifb.lsbyte = c_lsb;
    ifa.cs_sel = c_cs; ifb.cs_sel = c_cs;
    ifa.dataTx = c_tx; ifb.dataTx = c_tx;
  endtask

  // Serial stream of a word: bytes in wire order, each MSbit first
  function automatic logic [31:0] stream(input logic [31:0] w,
                                         input int b,
                                         input logic lsb);
    logic [31:0] s;
    logic [7:0]  byt;
    int          idx;
    s = '0;
    idx = 0;
    for (int kk = 0; kk < b; kk++) begin
      byt = lsb ? w[8*kk +: 8] : w[8*(b-1-kk) +: 8];
      for (int bb = 7; bb >= 0; bb--) begin
        s[idx] = byt[bb];
        idx++;
      end
    end
    return s;
  endfunction

  task automatic frame(input string nm,
                       input logic p_cpol, p_cpha,
                       input logic [7:0] p_div,
                       input logic [1:0] p_nb,
                       input logic p_lsb,
                       input logic [1:0] p_cs,
                       input logic [31:0] p_tx, p_sl,
                       input logic p_loop, p_restart);
    int          nb, nbits, lat, n, j, leads, l1, l2;
    int          ss_bad, ssb_bad;
    logic [31:0] mask, txs;
    logic        prev_sclk, prev_mosi, lead, fin;
    logic [3:0]  exp_ss;
    logic [2:0]  exp_ssb;
    exp_t        e;
    nb = int'(p_nb) + 1;
    nbits = 8 * nb;
    lat = (2 * nbits + 2) * (int'(p_div) + 1) + 2;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    txs = stream(p_tx, nb, p_lsb);
    sl_vec = stream(p_sl, nb, p_lsb);
    exp_q.push_back('{rx: (p_loop ? p_tx : p_sl) & mask, lat: lat});
    loop = p_loop;
    k = '0;
    @(negedge clk);
    set_cfg(p_cpol, p_cpha, p_div, p_nb, p_lsb, p_cs, p_tx);
    ifa.start = 1'b1; ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
    set_cfg(~p_cpol, ~p_cpha, 8'd3, ~p_nb, ~p_lsb, ~p_cs, ~p_tx);
    n = 1; j = 0; leads = 0; l1 = -1; l2 = -1;
    ss_bad = 0; ssb_bad = 0; fin = 1'b0;
    prev_sclk = p_cpol; prev_mosi = ifa.MOSI;
    while (!fin && n <= lat + 5) begin
      if (ifa.rdy) begin
        fin = 1'b1;
      end else begin
        ifa.start = (p_restart && n == 5);
        if (ifa.SCLK !== prev_sclk) begin
          lead = (prev_sclk == p_cpol);
          if (lead) begin
            leads++;
            if (l1 < 0) l1 = n;
            else if (l2 < 0) l2 = n;
          end
          if (lead ^ p_cpha) begin
            chk($sformatf("%s.mosi%0d", nm, j), 32'(prev_mosi),
                32'(txs[j[4:0]]));
            j++;
            k = k + 1'b1;
          end
        end
        exp_ss = (n <= lat - 2) ? ~(4'b1 << p_cs) : 4'hF;
        exp_ssb = (n <= lat - 2) ? ~(3'b1 << p_cs) : 3'h7;
        if (ifa.SS_n !== exp_ss) ss_bad++;
        if (ifb.SS_n !== exp_ssb) ssb_bad++;
        prev_sclk = ifa.SCLK;
        prev_mosi = ifa.MOSI;
        @(negedge clk);
        n++;
      end
    end
    ifa.start = 1'b0;
    e = exp_q.pop_front();
    chk({nm, ".latency"}, n, e.lat);
    chk({nm, ".dataRx"}, ifa.dataRx, e.rx);
    chk({nm, ".nbits"}, j, nbits);
    chk({nm, ".pulses"}, leads, nbits);
    chk({nm, ".period"}, l2 - l1, 2 * (int'(p_div) + 1));
    chk({nm, ".ss_seq"}, ss_bad, 0);
    chk({nm, ".sclk_idle"}, 32'(ifa.SCLK), 32'(p_cpol));
    chk({nm, ".mosi_idle"}, 32'(ifa.MOSI), 32'd1);
    chk({nm, ".ss_idle"}, 32'(ifa.SS_n), 32'hF);
    chk({nm, ".b_ss_seq"}, ssb_bad, 0);
    chk({nm, ".b_rdy"}, 32'(ifb.rdy), 32'd1);
    chk({nm, ".b_dataRx"}, ifb.dataRx, p_tx & mask);
  endtask

  initial begin
    ifa.start = 1'b0; ifb.start = 1'b0;
    set_cfg(1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst.rdy", 32'(ifa.rdy), 32'd1);
    chk("rst.dataRx", ifa.dataRx, 32'd0);
    chk("rst.mosi", 32'(ifa.MOSI), 32'd1);
    chk("rst.sclk", 32'(ifa.SCLK), 32'd0);
    chk("rst.ss", 32'(ifa.SS_n), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    frame("m0", 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0,
          32'h0000_00A5, 32'h0, 1'b1, 1'b0);
    frame("m3", 1'b1, 1'b1, 8'd1, 2'd3, 1'b1, 2'd1,
          32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b0);
    frame("m1", 1'b0, 1'b1, 8'd2, 2'd1, 1'b0, 2'd0,
          32'h0000_8001, 32'h0, 1'b1, 1'b0);
    frame("m2", 1'b1, 1'b0, 8'd2, 2'd1, 1'b0, 2'd1,
          32'h0000_8001, 32'h0, 1'b1, 1'b0);
    frame("slow", 1'b0, 1'b0, 8'd46, 2'd0, 1'b0, 2'd2,
          32'h0000_003C, 32'h0, 1'b1, 1'b0);
    frame("restart", 1'b0, 1'b0, 8'd3, 2'd2, 1'b0, 2'd0,
          32'h00AB_CDEF, 32'h0, 1'b1, 1'b1);
    frame("cs3", 1'b0, 1'b0, 8'd0, 2'd0, 1'b1, 2'd3,
          32'h0000_005A, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    set_cfg(1'b0, 1'b0, 8'd2, 2'd1, 1'b0, 2'd1, 32'h0000_1234);
    ifa.start = 1'b1; ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid.busy", 32'(ifa.rdy), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.rdy", 32'(ifa.rdy), 32'd1);
    chk("arst.dataRx", ifa.dataRx, 32'd0);
    chk("arst.mosi", 32'(ifa.MOSI), 32'd1);
    chk("arst.sclk", 32'(ifa.SCLK), 32'd0);
    chk("arst.ss", 32'(ifa.SS_n), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    frame("post", 1'b0, 1'b0, 8'd1, 2'd1, 1'b1, 2'd2,
          32'h0000_C3E1, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
